// File: rtl/press_generator.sv
// Button-press transmitter: queues direction requests and replays them as one-hot
// press pulses with fixed hold and release timing. Optional PRESS_COUNT_EN adds press_count.
module press_generator #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_dir,
  output logic       req_ready,
  input  logic       flush,
  output logic [3:0] pressed,
  output logic       busy
`ifdef PRESS_COUNT_EN
  ,
  output logic [15:0] press_count
`endif
);

  // state | meaning
  // IDLE  | no press in progress, waiting for a queued request
  // HOLD  | press line for the latched direction is high
  // GAP   | all lines low, enforcing the release interval

  localparam int AW  = $clog2(DEPTH);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW  = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [1:0]      dir, dir_d;
  logic [3:0]      pressed_d;

  logic [1:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, empty, push, pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign req_ready = ~full;
  assign push      = req_valid & ~full & ~flush;
  assign busy      = (state != IDLE) | ~empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_dir;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      dir     <= '0;
      pressed <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      dir     <= dir_d;
      pressed <= pressed_d;
    end
  end

  // flush suppresses every pop and forces an in-flight press into its release gap
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    dir_d   = dir;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && !empty) begin
          pop     = 1'b1;
          dir_d   = mem[rd_ptr];
          cnt_d   = HOLD_LOAD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (flush || cnt == '0) begin
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (!flush && !empty) begin
            pop     = 1'b1;
            dir_d   = mem[rd_ptr];
            cnt_d   = HOLD_LOAD;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pressed_d = 4'b0000;
    if (state_d == HOLD) pressed_d = 4'(1) << dir_d;
  end

`ifdef PRESS_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              press_count <= '0;
    else if (state_d == HOLD && state != HOLD) press_count <= press_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_press_generator.sv
// Randomized scoreboard bench for press_generator: requests are queued by the stimulus,
// and a monitor replays them against an event-level timing model each cycle.
module tb_press_generator;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;
  localparam int GAP   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_dir = 2'd0;
  logic       req_ready;
  logic       flush = 1'b0;
  logic [3:0] pressed;
  logic       busy;
`ifdef PRESS_COUNT_EN
  logic [15:0] press_count;
`endif

  press_generator #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_dir(req_dir),
    .req_ready(req_ready), .flush(flush), .pressed(pressed), .busy(busy)
`ifdef PRESS_COUNT_EN
    , .press_count(press_count)
`endif
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_fail   = 0;
  int        cyc      = 0;
  bit        mon_en   = 1'b0;
  bit        flush_now = 1'b0;
  logic [1:0] q [$];
  int        qcyc [$];
  bit        in_press = 1'b0;
  logic [1:0] cur_dir = 2'd0;
  int        rise_cyc = 0;
  int        fall_cyc = -100;
  int        starts   = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input bit v, input logic [1:0] d, input bit fl);
    @(negedge clk);
    #1;
    req_valid = v;
    req_dir   = d;
    flush     = fl;
    @(posedge clk);
    cyc++;
    flush_now = fl;
    if (fl) begin
      q.delete();
      qcyc.delete();
    end else if (v && q.size() < DEPTH) begin
      q.push_back(d);
      qcyc.push_back(cyc);
    end
  endtask

  // A press ends after HOLD cycles or on flush; the next starts once the oldest request
  // has been queued for an edge and GAP cycles have passed since the last release.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] exp_p;
      if (in_press) begin
        if (flush_now || cyc == rise_cyc + HOLD) begin
          in_press = 1'b0;
          fall_cyc = cyc;
        end
      end else if (q.size() > 0 && cyc >= qcyc[0] + 1 && cyc >= fall_cyc + GAP) begin
        in_press = 1'b1;
        cur_dir  = q.pop_front();
        void'(qcyc.pop_front());
        rise_cyc = cyc;
        starts++;
      end
      exp_p = in_press ? (4'(1) << cur_dir) : 4'b0000;
      check("pressed", 16'(pressed), 16'(exp_p));
      check("busy", 16'(busy), 16'(in_press || q.size() > 0 || cyc < fall_cyc + GAP));
      check("req_ready", 16'(req_ready), 16'(q.size() < DEPTH));
    end
  end

  task automatic drain();
    for (int k = 0; k < 200 && (q.size() > 0 || in_press || cyc < fall_cyc + GAP); k++)
      step(1'b0, 2'd0, 1'b0);
    check("drain_done", 16'(q.size() > 0 || in_press), 16'd0);
  endtask

  task automatic wait_press();
    for (int k = 0; k < 40 && !in_press; k++) step(1'b0, 2'd0, 1'b0);
    check("press_started", 16'(in_press), 16'd1);
  endtask

  initial begin
    #12;
    check("rst_pressed", 16'(pressed), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_ready", 16'(req_ready), 16'd1);
    @(negedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), $urandom_range(0, 49) == 0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
    drain();

    // fill to DEPTH, then keep offering while full
    for (int i = 0; i < 8; i++) step(1'b1, 2'(i), 1'b0);
    drain();

    // flush early in a press with requests still queued
    step(1'b1, 2'd3, 1'b0);
    step(1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd2, 1'b0);
    wait_press();
    step(1'b0, 2'd0, 1'b1);
    drain();

    // asynchronous reset in the middle of a press
    step(1'b1, 2'd2, 1'b0);
    wait_press();
    step(1'b0, 2'd0, 1'b0);
    #3;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("async_pressed", 16'(pressed), 16'd0);
    check("async_busy", 16'(busy), 16'd0);
    check("async_ready", 16'(req_ready), 16'd1);
    q.delete();
    qcyc.delete();
    in_press  = 1'b0;
    fall_cyc  = -100;
    flush_now = 1'b0;
    starts    = 0;
    @(negedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 9) < 5, 2'($urandom_range(0, 3)), $urandom_range(0, 39) == 0);
    drain();

`ifdef PRESS_COUNT_EN
    check("press_count", press_count, 16'(starts));
`endif
    @(negedge clk);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
